// File: rtl/ps2_scan_receiver_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver and its event FIFO.
package ps2_scan_receiver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic [7:0]  PrefixExt  = 8'hE0;
  localparam logic [7:0]  PrefixBrk  = 8'hF0;
  localparam int unsigned EventWidth = 10;
  localparam logic [7:0]  LedReset   = 8'h01;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO for decoded key events; drops pushes when full and flags it stickily.
module ps2_event_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             overflow_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign valid_o = (count_q != '0);
  assign do_pop  = valid_o && pop_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      if (push_i && !do_push) overflow_q <= 1'b1;
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  assign data_o     = mem_q[rptr_q];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronise and filter the lines, deframe bytes, fold E0/F0 prefixes
// into key events and queue them for a consumer.
module ps2_scan_receiver
  import ps2_scan_receiver_pkg::*;
#(
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned TIMEOUT_CYC  = 50000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          REPORT_BREAK = 1'b1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       PS2KeyboardClk,
  input  logic       PS2KeyboardData,
  output logic       eventValid,
  input  logic       eventReady,
  output logic [7:0] eventCode,
  output logic       eventBreak,
  output logic       eventExtended,
  output logic       parityErr,
  output logic       frameErr,
  output logic       overflow,
  output logic [7:0] led
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]            clk_sync_q, data_sync_q;
  logic [FILTER_LEN-1:0] clk_hist_q, data_hist_q;
  logic                  clk_filt_q, data_filt_q, clk_prev_q;
  logic                  strobe;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_hist_q  <= '1;
      data_hist_q <= '1;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2KeyboardClk};
      data_sync_q <= {data_sync_q[0], PS2KeyboardData};
      clk_hist_q  <= {clk_hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      data_hist_q <= {data_hist_q[FILTER_LEN-2:0], data_sync_q[1]};
      // A level only changes once the whole sample history agrees.
      if (&clk_hist_q) clk_filt_q <= 1'b1;
      else if (~|clk_hist_q) clk_filt_q <= 1'b0;
      if (&data_hist_q) data_filt_q <= 1'b1;
      else if (~|data_hist_q) data_filt_q <= 1'b0;
      clk_prev_q <= clk_filt_q;
    end
  end

  assign strobe = clk_prev_q && !clk_filt_q;

  ps2_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d, led_q, led_d;
  logic                  parity_q, parity_d, ext_q, ext_d, brk_q, brk_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d, push_q, push_d;
  logic [EventWidth-1:0] push_data_q, push_data_d;
  logic [WdW-1:0]        wd_q, wd_d;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      led_q       <= LedReset;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      led_q       <= led_d;
      wd_q        <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    led_d       = led_q;
    wd_d        = (state_q == StIdle || strobe) ? '0 : wd_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (strobe) begin
          if (!data_filt_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      StData: begin
        if (strobe) begin
          shift_d   = {data_filt_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (strobe) begin
          parity_d = data_filt_q;
          state_d  = StStop;
        end
      end
      StStop: begin
        if (strobe) begin
          state_d = StIdle;
          if (!data_filt_q || !odd_parity_ok(shift_q, parity_q)) begin
            ferr_d = !data_filt_q;
            perr_d = data_filt_q;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (shift_q == PrefixExt) begin
            ext_d = 1'b1;
          end else if (shift_q == PrefixBrk) begin
            brk_d = 1'b1;
          end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (!brk_q || REPORT_BREAK) begin
              push_d      = 1'b1;
              push_data_d = {ext_q, brk_q, shift_q};
            end
            if (!brk_q) led_d = shift_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !strobe && wd_q == WdW'(TIMEOUT_CYC - 1)) begin
      state_d   = StIdle;
      ferr_d    = 1'b1;
      bit_cnt_d = '0;
      ext_d     = 1'b0;
      brk_d     = 1'b0;
    end
  end

  logic [EventWidth-1:0] head;

  ps2_event_fifo #(
    .Width(EventWidth),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstN       (rstN),
    .push_i     (push_q),
    .push_data_i(push_data_q),
    .pop_i      (eventReady),
    .valid_o    (eventValid),
    .data_o     (head),
    .overflow_o (overflow)
  );

  assign eventExtended = head[9];
  assign eventBreak    = head[8];
  assign eventCode     = head[7:0];
  assign parityErr     = perr_q;
  assign frameErr      = ferr_q;
  assign led           = led_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench: two receivers (break reporting on and off) share one PS/2 stimulus stream.
module tb_ps2_scan_receiver;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 300;
  localparam int          Hp    = 20;

  logic clk = 1'b0, rstN = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, ready = 1'b1;
  logic       v_a, b_a, x_a, pe_a, fe_a, ov_a, v_b, b_b, x_b, pe_b, fe_b, ov_b;
  logic [7:0] c_a, led_a, c_b, led_b;

  always #5 clk = ~clk;

  ps2_scan_receiver #(.FILTER_LEN(4), .TIMEOUT_CYC(Tmo), .FIFO_DEPTH(Depth), .REPORT_BREAK(1'b1))
  dut (
    .clk(clk), .rstN(rstN), .PS2KeyboardClk(ps2_clk), .PS2KeyboardData(ps2_data),
    .eventValid(v_a), .eventReady(ready), .eventCode(c_a), .eventBreak(b_a),
    .eventExtended(x_a), .parityErr(pe_a), .frameErr(fe_a), .overflow(ov_a), .led(led_a)
  );

  ps2_scan_receiver #(.FILTER_LEN(4), .TIMEOUT_CYC(Tmo), .FIFO_DEPTH(Depth), .REPORT_BREAK(1'b0))
  dut_nb (
    .clk(clk), .rstN(rstN), .PS2KeyboardClk(ps2_clk), .PS2KeyboardData(ps2_data),
    .eventValid(v_b), .eventReady(ready), .eventCode(c_b), .eventBreak(b_b),
    .eventExtended(x_b), .parityErr(pe_b), .frameErr(fe_b), .overflow(ov_b), .led(led_b)
  );

  int checks = 0, errors = 0;
  logic [9:0] q_a[$], q_b[$];
  bit ext_m = 0, brk_m = 0, ovf_m = 0;
  logic [7:0] led_m = 8'h01;
  int perr_exp = 0, ferr_exp = 0;
  int perr_a = 0, ferr_a = 0, perr_b = 0, ferr_b = 0;
  bit rand_ready = 0, ready_fixed = 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: one per instance, popping whenever a transfer happens.
  always @(negedge clk) begin
    if (rstN) begin
      if (v_a && ready) begin
        if (q_a.size() == 0) chk("event_a_unexpected", {x_a, b_a, c_a}, 10'h3ff);
        else chk("event_a", {x_a, b_a, c_a}, q_a.pop_front());
      end
      if (v_b && ready) begin
        if (q_b.size() == 0) chk("event_nb_unexpected", {x_b, b_b, c_b}, 10'h3ff);
        else chk("event_nb", {x_b, b_b, c_b}, q_b.pop_front());
      end
      if (pe_a || fe_a) chk("err_exclusive_a", pe_a & fe_a, 0);
      if (pe_a) perr_a++;
      if (fe_a) ferr_a++;
      if (pe_b) perr_b++;
      if (fe_b) ferr_b++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Reference model of one complete frame, applied when the frame is issued.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [9:0] ev;
    if (bad_stop) begin
      ferr_exp++; ext_m = 0; brk_m = 0;
    end else if (bad_par) begin
      perr_exp++; ext_m = 0; brk_m = 0;
    end else if (b == 8'hE0) ext_m = 1;
    else if (b == 8'hF0) brk_m = 1;
    else begin
      ev = {ext_m, brk_m, b};
      if (q_a.size() < Depth) q_a.push_back(ev); else ovf_m = 1;
      if (!brk_m) begin
        if (q_b.size() < Depth) q_b.push_back(ev);
        led_m = b;
      end
      ext_m = 0; brk_m = 0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_cyc(Hp);
      ps2_clk = 1'b0;
      wait_cyc(Hp);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    logic par;
    par = ~^b ^ bad_par;
    model_frame(b, bad_par, bad_stop);
    drive_bits({~bad_stop, par, b, 1'b0}, 11);
    wait_cyc(Hp);
    chk("led_a", led_a, led_m);
    chk("led_nb", led_b, led_m);
    chk("parity_err_count", perr_a, perr_exp);
    chk("frame_err_count", ferr_a, ferr_exp);
    chk("frame_err_count_nb", ferr_b + perr_b, ferr_exp + perr_exp);
  endtask

  initial begin
    logic [7:0] rb;
    wait_cyc(3);
    chk("rst_valid", v_a, 0);
    chk("rst_code", {x_a, b_a, c_a}, 0);
    chk("rst_led", led_a, 8'h01);
    chk("rst_errs", {pe_a, fe_a, ov_a}, 0);
    rstN = 1'b1;
    wait_cyc(10);

    send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h75);
    send(8'h1C, 1'b1);
    send(8'h32);

    // Clock stalls high after the start bit and four data bits.
    drive_bits({2'b11, 8'h5A, 1'b0}, 5);
    ferr_exp++; ext_m = 0; brk_m = 0;
    wait_cyc(Tmo + 50);
    chk("timeout_ferr", ferr_a, ferr_exp);
    send(8'h29);

    ready_fixed = 0;
    wait_cyc(2);
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
    chk("overflow_a", ov_a, ovf_m);
    chk("overflow_nb", ov_b, ovf_m);
    chk("full_valid", v_a, 1);
    ready_fixed = 1;
    wait_cyc(20);
    chk("drained_a", q_a.size(), 0);

    rand_ready = 1;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        default: begin
          rb = 8'($urandom_range(0, 255));
          if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h1C;
        end
      endcase
      send(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
    rand_ready = 0;
    wait_cyc(20);
    chk("drained_rand_a", q_a.size(), 0);
    chk("drained_rand_nb", q_b.size(), 0);

    // Reset in the middle of a frame with overflow still set.
    drive_bits({2'b11, 8'h44, 1'b0}, 5);
    rstN = 1'b0;
    wait_cyc(5);
    chk("midrst_led", led_a, 8'h01);
    chk("midrst_ovf", ov_a, 0);
    chk("midrst_valid", v_a, 0);
    rstN = 1'b1;
    led_m = 8'h01; ext_m = 0; brk_m = 0;
    wait_cyc(2 * Tmo);
    chk("midrst_no_ferr", ferr_a, ferr_exp);
    chk("midrst_no_perr", perr_a, perr_exp);
    chk("midrst_no_event", v_a | v_b, 0);
    send(8'h1C);
    wait_cyc(20);
    chk("final_q_a", q_a.size(), 0);
    chk("final_q_nb", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
